// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard detection and operand forwarding for the in-order pipeline.
// Optional counters are enabled with `define HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned SELW       = $clog2(NUM_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic              stall,
    output logic [SELW-1:0]   fwd_sel1,
    output logic [SELW-1:0]   fwd_sel2
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]       stat_stall_cycles,
    output logic [31:0]       stat_fwd_events
`endif
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
    } entry_t;

    entry_t sb_q [NUM_STAGES:1];
    entry_t sb_d [NUM_STAGES:1];

    logic late_ld1;
    logic late_ld2;

    // Scan oldest to youngest so the smallest matching index is the one left standing.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        late_ld1 = 1'b0;
        late_ld2 = 1'b0;
        for (int unsigned k = NUM_STAGES; k >= 1; k--) begin
            if (sb_q[k].valid && sb_q[k].wr && (sb_q[k].rd == id_rs1) &&
                (id_rs1 != '0) && id_use_rs1 && id_valid) begin
                fwd_sel1 = SELW'(k);
                late_ld1 = sb_q[k].ld && (k < LOAD_READY);
            end
            if (sb_q[k].valid && sb_q[k].wr && (sb_q[k].rd == id_rs2) &&
                (id_rs2 != '0) && id_use_rs2 && id_valid) begin
                fwd_sel2 = SELW'(k);
                late_ld2 = sb_q[k].ld && (k < LOAD_READY);
            end
        end
        stall = late_ld1 | late_ld2;
    end

    always_comb begin
        for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
            sb_d[k] = '0;
        end
        if (id_valid && !stall && !flush) begin
            sb_d[1].valid = 1'b1;
            sb_d[1].rd    = id_rd;
            sb_d[1].wr    = id_reg_write;
            sb_d[1].ld    = id_mem_read;
        end
        for (int unsigned k = 2; k <= NUM_STAGES; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall && !flush) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!stall && id_valid) begin
                fwd_cnt_q <= fwd_cnt_q + 32'(fwd_sel1 != '0) + 32'(fwd_sel2 != '0);
            end
        end
    end

    assign stat_stall_cycles = stall_cnt_q;
    assign stat_fwd_events   = fwd_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
